prbs31_checker: RTL and testbench
=================================

# prbs31_checker

Receive-side counterpart to the chip's PRBS31 generator: accepts a serial bit stream with a valid qualifier and self-synchronises to the x^31 + x^28 + 1 sequence. Once locked, it flywheels on its own prediction and counts bit errors. The block declares loss of lock on a burst of errors. It sits as a Tiny Tapeout user project: error count on `uo_out`, status on `uio_out`.

## Interface
- `ERR_W`, 16: error counter width; counter saturates at all-ones.
- `LOSS_ERRS`, 8: errors within one window that force loss of lock.
- `WIN_LEN`, 64: window length in valid bits.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `ena`  in  1: powered indicator; ignored.
- `ui_in`  in  8: control and data inputs.
  - [0] serial data.
  - [1] bit valid.
  - [2] synchronous clear of error counter.
  - [3] byte select (0 = count[7:0], 1 = count[15:8]).
  - [7:4] unused.
- `uo_out`  out  8: selected byte of the error counter; combinational mux from registered count.
- `uio_in`  in  8: unused.
- `uio_out`  out  8: status bits, all registered.
  - [0] lock.
  - [1] err_pulse.
  - [2] count saturated.
  - [4:3] state (00 FILL, 01 HUNT, 10 LOCK).
  - [7:5] 0.
- `uio_oe`  out  8: constant 8'hFF.

## Operation
- Shift register `sr[30:0]`; `sr[0]` is the newest bit. Predicted bit is `sr[30] ^ sr[27]`. This matches the generator's feedback.
- All state advances only on edges where `ui_in[1]` = 1, except clear and err_pulse.
- **FILL**:
  - Each valid bit shifts into `sr`; a fill counter increments.
  - After the 31st valid bit, go to HUNT with the match counter at 0.
- **HUNT**:
  - Each valid bit is compared to the prediction, then shifted into `sr` (self-sync).
  - On a match with `sr` ≠ 0, the match counter increments.
  - On a mismatch, or if `sr` = 0, the match counter clears. This prevents false lock on an all-zero stream.
  - When the match counter reaches 32, go to LOCK. The window counter and window error counter clear at the same time.
  - Errors are not counted in HUNT.
- **LOCK**:
  - `sr` shifts in the predicted bit (flywheel), not the received bit, so one flipped bit counts exactly one error.
  - On a mismatch, the error count increments (holding at all-ones once saturated) and the window error counter increments.
  - The window counter counts valid bits modulo WIN_LEN. At wrap, the window error counter clears.
  - When the window error counter reaches LOSS_ERRS, go to FILL:
    - Clear `sr` and all fill, match and window counters.
    - Retain the error count.
    - Lock drops on that same edge.
- **Clear** (`ui_in[2]`) zeroes the error count and the saturated flag on the next edge. It has priority over a simultaneous increment. It does not affect state or lock.
- **Saturated flag** sets when the count reaches all-ones and stays set until clear or reset.

## Timing
- Reset (async assert, sync release) sets:
  - state FILL, `sr` 0, all counters 0;
  - `uo_out` 0, `uio_out` 0;
  - `uio_oe` 8'hFF at all times.
- err_pulse is high for exactly one cycle, on the edge that sampled the erroneous bit. It is 0 on all other cycles, including invalid cycles.
- Lock latency from reset with a clean stream: lock rises on the edge that samples the 63rd valid bit (31 fill + 32 matches).
- The error count updates on the same edge as err_pulse. `uo_out` reflects it combinationally after that edge.
- Simultaneous events:
  - mismatch and window wrap on the same edge: the error counts in the closing window, then the window error counter clears;
  - LOSS_ERRS reached on the wrap edge: loss takes priority.
- Reset mid-LOCK returns to FILL immediately; the error count is lost.
- Gaps in valid (`ui_in[1]` = 0) freeze all state; there is no timeout.

## Test plan
- **Clean lock**: reset, then a PRBS31 stream seeded at 1, one bit per cycle, valid=1.
  - Lock rises on the 63rd valid bit; state = 10.
  - Count = 0 after 2000 bits; no err_pulse ever.
- **Single error**: in LOCK, flip bit 500.
  - One err_pulse on the edge that samples bit 500.
  - Count = 1, `uo_out` = 8'h01 with sel=0 and 8'h00 with sel=1; lock stays high.
- **Burst loss and reacquire**: flip 8 bits within one 64-bit window.
  - Lock drops on the edge of the 8th error; count = 8.
  - Clean stream continues: lock returns 63 valid bits later, count stays 8.
- **Zero stream**: all-zero input with valid=1 for 500 cycles → state never leaves FILL/HUNT, lock = 0.
- **Gapped valid**: repeat Clean lock and Single error with valid toggling every other cycle.
  - Identical counts; lock on the 63rd valid bit, not the 63rd cycle.
- **Clear and saturation**: ERR_W forced to 4; inject 20 errors, spaced 16 apart so lock holds.
  - Count holds at 4'hF with saturated = 1.
  - Assert clear on the same cycle as a mismatch: count = 0 and saturated = 0 next cycle.
  - Async reset pulse mid-LOCK: all outputs 0 immediately.

Source files
------------

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-syncs, flywheels once locked,
// counts bit errors and drops lock on an error burst within a window.
module prbs31_checker #(
    parameter int ERR_W     = 16,
    parameter int LOSS_ERRS = 8,
    parameter int WIN_LEN   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int WCW = $clog2(WIN_LEN);
    localparam int EEW = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        FILL = 2'b00,
        HUNT = 2'b01,
        LOCK = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [30:0]      sr_q, sr_d;
    logic [4:0]       fill_q, fill_d;
    logic [5:0]       match_q, match_d;
    logic [WCW-1:0]   win_q, win_d;
    logic [EEW-1:0]   werr_q, werr_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             pulse_q, pulse_d;
    logic             lock_q, lock_d;

    logic             din, vld, clr;
    logic             pred, mis, err, loss, wrap, hit;
    logic [EEW-1:0]   werr_inc;
    logic [15:0]      cnt16;

    assign din  = ui_in[0];
    assign vld  = ui_in[1];
    assign clr  = ui_in[2];
    assign pred = sr_q[30] ^ sr_q[27];
    assign mis  = din ^ pred;
    // A match only counts toward lock while the register holds a nonzero state
    assign hit  = ~mis & (|sr_q);
    assign err  = vld & (state_q == LOCK) & mis;
    assign wrap = (win_q == WCW'(WIN_LEN - 1));
    assign werr_inc = werr_q + EEW'(mis);
    assign loss = err & (werr_inc == EEW'(LOSS_ERRS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vld) begin
            unique case (state_q)
                FILL:    if (fill_q == 5'd30) state_d = HUNT;
                HUNT:    if (hit && match_q == 6'd31) state_d = LOCK;
                LOCK:    if (loss) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        sr_d    = sr_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        if (vld) begin
            unique case (state_q)
                FILL: begin
                    sr_d    = {sr_q[29:0], din};
                    fill_d  = (fill_q == 5'd30) ? 5'd0 : fill_q + 5'd1;
                    match_d = 6'd0;
                end
                HUNT: begin
                    sr_d    = {sr_q[29:0], din};
                    match_d = hit ? match_q + 6'd1 : 6'd0;
                    if (hit && match_q == 6'd31) begin
                        match_d = 6'd0;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                LOCK: begin
                    // Flywheel: a corrupted input bit never enters the register
                    sr_d   = {sr_q[29:0], pred};
                    win_d  = wrap ? '0 : win_q + WCW'(1);
                    werr_d = wrap ? '0 : werr_inc;
                    if (loss) begin
                        sr_d    = '0;
                        fill_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end
                end
                default: begin
                    sr_d = '0;
                end
            endcase
        end
        pulse_d = err;
        lock_d  = (state_d == LOCK);
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (err && !(&cnt_q)) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
        sat_d = clr ? 1'b0 : (sat_q | (&cnt_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            pulse_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            pulse_q <= pulse_d;
            lock_q  <= lock_d;
        end
    end

    assign cnt16   = 16'(cnt_q);
    assign uo_out  = ui_in[3] ? cnt16[15:8] : cnt16[7:0];
    assign uio_out = {3'b000, state_q, sat_q, pulse_q, lock_q};
    assign uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock, single/burst errors, zero stream,
// gapped valid, clear and saturation on a narrow-counter instance.
module tb_prbs31_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo4, uio4, oe4;

    int total = 0;
    int bad = 0;

    logic [30:0] g;
    int  vb;
    int  f0, fs, nf;
    int  loss_bit, relock_bit;
    bit  zero, clr_v, sel_v;

    always #5 clk = ~clk;

    prbs31_checker dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    prbs31_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uo_out(uo4), .uio_in(uio_in), .uio_out(uio4), .uio_oe(oe4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_flip(input int n);
        if (nf == 0 || n < f0) return 1'b0;
        return ((n - f0) % fs == 0) && ((n - f0) / fs < nf);
    endfunction

    function automatic logic lock_exp();
        if (vb < 63) return 1'b0;
        if (vb >= loss_bit && vb < relock_bit) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(input logic v, input logic flip);
        logic b;
        @(negedge clk);
        b = 1'b0;
        if (v) begin
            if (!zero) begin
                b = g[30] ^ g[27];
                g = {g[29:0], b};
            end
            vb++;
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        ui_in = {4'b0000, sel_v, clr_v, v, b ^ flip};
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int last, input bit gap);
        bit fl;
        while (vb < last) begin
            if (gap) begin
                drive(1'b0, 1'b0);
                chk("gap_pulse", uio_out[1], 0);
                chk("gap_lock", uio_out[0], lock_exp());
            end
            fl = is_flip(vb + 1);
            drive(1'b1, fl);
            chk("pulse", uio_out[1], fl);
            chk("lock", uio_out[0], lock_exp());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h00;
        g = 31'd1;
        vb = 0;
        f0 = 0; fs = 1; nf = 0;
        loss_bit = 1 << 30; relock_bit = 1 << 30;
        zero = 1'b0; clr_v = 1'b0; sel_v = 1'b0;
        #1;
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Clean lock
        do_reset();
        run_to(2000, 1'b0);
        chk("clean_state", uio_out[4:3], 2'b10);
        chk("clean_cnt", uo_out, 8'h00);

        // Single error at bit 500, then clear, then burst loss and reacquire
        do_reset();
        f0 = 500; nf = 1;
        run_to(600, 1'b0);
        chk("single_cnt", uo_out, 8'h01);
        sel_v = 1'b1;
        drive(1'b0, 1'b0);
        chk("single_hi", uo_out, 8'h00);
        chk("single_lock", uio_out[0], 1'b1);
        sel_v = 1'b0;
        clr_v = 1'b1;
        drive(1'b0, 1'b0);
        clr_v = 1'b0;
        chk("clr_cnt", uo_out, 8'h00);
        f0 = 1000; nf = 8; fs = 1;
        loss_bit = 1007; relock_bit = 1070;
        run_to(1007, 1'b0);
        chk("burst_cnt", uo_out, 8'h08);
        chk("burst_state", uio_out[4:3], 2'b00);
        run_to(1200, 1'b0);
        chk("relock_cnt", uo_out, 8'h08);
        chk("relock_state", uio_out[4:3], 2'b10);

        // All-zero stream never locks
        do_reset();
        zero = 1'b1;
        repeat (500) begin
            drive(1'b1, 1'b0);
            chk("zero_lock", uio_out[0], 1'b0);
            chk("zero_st", uio_out[4], 1'b0);
        end
        zero = 1'b0;

        // Gapped valid
        do_reset();
        f0 = 500; nf = 1;
        run_to(700, 1'b1);
        chk("gap_cnt", uo_out, 8'h01);
        chk("gap_state", uio_out[4:3], 2'b10);

        // Saturation on the 4-bit counter, clear vs mismatch, async reset
        do_reset();
        f0 = 101; fs = 16; nf = 20;
        run_to(410, 1'b0);
        chk("sat_cnt4", uo4, 8'h0F);
        chk("sat_flag4", uio4[2], 1'b1);
        chk("sat_lock4", uio4[0], 1'b1);
        chk("cnt16", uo_out, 8'h14);
        chk("sat_flag16", uio_out[2], 1'b0);
        f0 = vb + 1; fs = 1; nf = 1;
        clr_v = 1'b1;
        run_to(vb + 1, 1'b0);
        clr_v = 1'b0;
        chk("clrmis_cnt4", uo4, 8'h00);
        chk("clrmis_sat4", uio4[2], 1'b0);
        chk("clrmis_cnt16", uo_out, 8'h00);
        f0 = vb + 5;
        run_to(vb + 10, 1'b0);
        chk("post_cnt4", uo4, 8'h01);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_uo4", uo4, 8'h00);
        chk("arst_uio4", uio4, 8'h00);
        chk("arst_uo", uo_out, 8'h00);
        chk("arst_uio", uio_out, 8'h00);
        chk("arst_oe4", oe4, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
